mm_compute_ctrl: RTL and testbench

Compute-phase sequencer for the matrix-multiply accelerator. On a start edge it walks the i/j/k triple loop over A[DIM][DIM] and B[DIM][DIM]. It drives read addresses and enables for the A and B BRAMs and accumulate/clear strobes for the MAC, then writes each finished dot product into the R BRAM. It sits between the AXI-Lite `start` bit and the three `bram` instances plus the `MAC` inside `mat_mul`, replacing the unimplemented calculate state of the load/store address generator.

---
 rtl/mm_pkg.sv | 23 ++
 rtl/mm_delay_line.sv | 27 ++
 rtl/mm_compute_ctrl.sv | 152 +++++++++++++++
 tb/tb_mm_compute_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types for the matrix-multiply compute sequencer: FSM states,
// MAC strobe encoding and the BRAM address-width derivation.
package mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // bit0 = accumulate, bit1 = clear (load product instead of adding)
    typedef enum logic [1:0] {
        MAC_NOP  = 2'b00,
        MAC_ACC  = 2'b01,
        MAC_LOAD = 2'b11
    } mac_op_e;

    function automatic int mm_size_log(input int dim_log);
        return 2 * dim_log;
    endfunction

endpackage

// File: rtl/mm_delay_line.sv
// Shift register of DEPTH stages, W bits wide, advanced only when i_en is high.
// Latency DEPTH enabled cycles; a low i_en freezes every stage in place.
module mm_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_dat,
    output logic [W-1:0] o_dat
);

    logic [W-1:0] r_sr [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int d = 0; d < DEPTH; d++) r_sr[d] <= '0;
        end else if (i_en) begin
            r_sr[0] <= i_dat;
            for (int d = 1; d < DEPTH; d++) r_sr[d] <= r_sr[d-1];
        end
    end

    assign o_dat = r_sr[DEPTH-1];

endmodule

// File: rtl/mm_compute_ctrl.sv
// Compute-phase sequencer: walks i/j/k over A and B, strobes the MAC and writes R.
// Optional busy-cycle counter enabled by defining MM_CTRL_CYCLE_CNT_EN.
module mm_compute_ctrl
    import mm_pkg::*;
#(
    parameter  int DIM_LOG  = 1,
    parameter  int RD_LAT   = 1,
    localparam int SIZE_LOG = mm_size_log(DIM_LOG)
) (
    input  logic                s00_axi_aclk,
    input  logic                s00_axi_aresetn,
    input  logic                start,
    input  logic                hold,
    output logic                busy,
    output logic                done,
    output logic                en_A,
    output logic                en_B,
    output logic [SIZE_LOG-1:0] addr_A,
    output logic [SIZE_LOG-1:0] addr_B,
    output logic                mac_acc,
    output logic                mac_clear,
    output logic                en_R,
    output logic                rw_R,
    output logic [SIZE_LOG-1:0] addr_R,
    output logic [31:0]         cycle_cnt
);

    localparam logic [DIM_LOG-1:0] IDX_MAX    = '1;
    localparam int                 DRW        = $clog2(RD_LAT + 1);
    localparam logic [DRW-1:0]     DRAIN_LAST = DRW'(RD_LAT);
    localparam int                 PW         = 3 + SIZE_LOG;

    state_e             r_state;
    logic               r_start_d;
    logic [DIM_LOG-1:0] r_i, r_j, r_k;
    logic [DRW-1:0]     r_drain_cnt;

    logic               w_start_edge;
    logic               w_issue;
    logic               w_busy;
    logic [PW-1:0]      w_p0_in, w_p0_out;
    logic [SIZE_LOG:0]  w_p1_in, w_p1_out;
    logic               w_mac_vld, w_mac_first, w_mac_last;
    mac_op_e            w_mac_op;
    logic               w_wr;

    assign w_start_edge = start & ~r_start_d;
    assign w_busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_issue      = (r_state == ST_RUN) && !hold;

    // DRAIN lasts exactly RD_LAT+1 unheld cycles: that is when the final R write leaves the pipe
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state     <= ST_IDLE;
            r_start_d   <= 1'b0;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_start_d <= start;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!hold) begin
                        r_k <= r_k + 1'b1;
                        if (r_k == IDX_MAX) begin
                            r_j <= r_j + 1'b1;
                            if (r_j == IDX_MAX) begin
                                r_i <= r_i + 1'b1;
                                if (r_i == IDX_MAX) r_state <= ST_DRAIN;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!hold) begin
                        if (r_drain_cnt == DRAIN_LAST) begin
                            r_drain_cnt <= '0;
                            r_state     <= ST_DONE;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_p0_in = {w_issue, (r_k == '0), (r_k == IDX_MAX), r_i, r_j};

    mm_delay_line #(.W(PW), .DEPTH(RD_LAT)) u_rd_pipe (
        .i_clk   (s00_axi_aclk),
        .i_rst_n (s00_axi_aresetn),
        .i_en    (!hold),
        .i_dat   (w_p0_in),
        .o_dat   (w_p0_out)
    );

    assign w_mac_vld   = w_p0_out[PW-1];
    assign w_mac_first = w_p0_out[PW-2];
    assign w_mac_last  = w_p0_out[PW-3];
    assign w_mac_op    = (hold || !w_mac_vld) ? MAC_NOP :
                         (w_mac_first ? MAC_LOAD : MAC_ACC);

    // One extra stage so R is written after the MAC result register has settled
    assign w_p1_in = {w_mac_vld & w_mac_last, w_p0_out[SIZE_LOG-1:0]};

    mm_delay_line #(.W(SIZE_LOG + 1), .DEPTH(1)) u_wr_pipe (
        .i_clk   (s00_axi_aclk),
        .i_rst_n (s00_axi_aresetn),
        .i_en    (!hold),
        .i_dat   (w_p1_in),
        .o_dat   (w_p1_out)
    );

    assign w_wr = w_p1_out[SIZE_LOG] && !hold;

    assign busy      = w_busy;
    assign done      = (r_state == ST_DONE);
    assign en_A      = w_issue;
    assign en_B      = w_issue;
    assign addr_A    = {r_i, r_k};
    assign addr_B    = {r_k, r_j};
    assign mac_acc   = w_mac_op[0];
    assign mac_clear = w_mac_op[1];
    assign en_R      = w_wr;
    assign rw_R      = w_wr;
    assign addr_R    = w_wr ? w_p1_out[SIZE_LOG-1:0] : '0;

`ifdef MM_CTRL_CYCLE_CNT_EN
    logic [31:0] r_cycle_cnt;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_cycle_cnt <= '0;
        end else if ((r_state == ST_IDLE) && w_start_edge) begin
            r_cycle_cnt <= '0;
        end else if (w_busy && (r_cycle_cnt != '1)) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_mm_compute_ctrl.sv
// Directed bench: DIM=2/RD_LAT=1 sequencing, hold, restart and reset cases,
// plus a DIM=4/RD_LAT=2 run through a behavioural BRAM+MAC model.
module tb_mm_compute_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, start1, hold1;
    logic        busy1, done1, en_A1, en_B1, mac_acc1, mac_clear1, en_R1, rw_R1;
    logic [1:0]  addr_A1, addr_B1, addr_R1;
    logic [31:0] cycle_cnt1;

    logic        rst2, start2, hold2;
    logic        busy2, done2, en_A2, en_B2, mac_acc2, mac_clear2, en_R2, rw_R2;
    logic [3:0]  addr_A2, addr_B2, addr_R2;
    logic [31:0] cycle_cnt2;

    mm_compute_ctrl #(.DIM_LOG(1), .RD_LAT(1)) u_dut1 (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst1), .start(start1), .hold(hold1),
        .busy(busy1), .done(done1), .en_A(en_A1), .en_B(en_B1),
        .addr_A(addr_A1), .addr_B(addr_B1), .mac_acc(mac_acc1), .mac_clear(mac_clear1),
        .en_R(en_R1), .rw_R(rw_R1), .addr_R(addr_R1), .cycle_cnt(cycle_cnt1)
    );

    mm_compute_ctrl #(.DIM_LOG(2), .RD_LAT(2)) u_dut2 (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst2), .start(start2), .hold(hold2),
        .busy(busy2), .done(done2), .en_A(en_A2), .en_B(en_B2),
        .addr_A(addr_A2), .addr_B(addr_B2), .mac_acc(mac_acc2), .mac_clear(mac_clear2),
        .en_R(en_R2), .rw_R(rw_R2), .addr_R(addr_R2), .cycle_cnt(cycle_cnt2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural BRAMs (2-cycle read) and MAC for the DIM=4 instance
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [7:0] a_s1, a_s2, b_s1, b_s2;
    int         acc;
    int         r_mem [16];

    always @(posedge clk) begin
        if (en_A2) a_s1 <= mem_a[addr_A2];
        if (en_B2) b_s1 <= mem_b[addr_B2];
        a_s2 <= a_s1;
        b_s2 <= b_s1;
        if (mac_acc2) acc <= mac_clear2 ? int'(a_s2) * int'(b_s2)
                                        : acc + int'(a_s2) * int'(b_s2);
        if (en_R2 && rw_R2) r_mem[addr_R2] <= acc;
    end

    // Observations from the last run of the DIM=2 instance
    int ia[$], ib[$], rw_cyc[$], rw_addr[$], done_cyc[$], mac_cyc[$], clr_cyc[$];
    int busy_n, held_strobes, bad_rw;
    logic [31:0] cnt_max;

    int exp_a[8]    = '{0, 1, 0, 1, 2, 3, 2, 3};
    int exp_b[8]    = '{0, 2, 1, 3, 0, 2, 1, 3};
    int exp_clr[4]  = '{2, 4, 6, 8};
    int wc_plain[4] = '{4, 6, 8, 10};
    int wc_hold[4]  = '{7, 9, 11, 13};

    // Cycle n is the one that starts at the n-th rising edge after the start edge
    task automatic run1(input int ncyc, input int h_from, input int h_len,
                        input int lo_at, input int hi_at);
        ia.delete(); ib.delete(); rw_cyc.delete(); rw_addr.delete();
        done_cyc.delete(); mac_cyc.delete(); clr_cyc.delete();
        busy_n = 0; held_strobes = 0; bad_rw = 0; cnt_max = 0;
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk);
            #1;
            hold1 = (n >= h_from) && (n < h_from + h_len);
            if (n == lo_at) start1 = 1'b0;
            if (n == hi_at) start1 = 1'b1;
            @(negedge clk);
            if (en_A1) begin ia.push_back(int'(addr_A1)); ib.push_back(int'(addr_B1)); end
            if (en_A1 != en_B1) bad_rw++;
            if (en_R1) begin rw_cyc.push_back(n); rw_addr.push_back(int'(addr_R1)); end
            if (en_R1 != rw_R1) bad_rw++;
            if (mac_clear1 && !mac_acc1) bad_rw++;
            if (mac_acc1) mac_cyc.push_back(n);
            if (mac_clear1) clr_cyc.push_back(n);
            if (done1) done_cyc.push_back(n);
            if (busy1) busy_n++;
            if (hold1 && (en_A1 | en_B1 | mac_acc1 | mac_clear1 | en_R1 | rw_R1)) held_strobes++;
            if (cycle_cnt1 > cnt_max) cnt_max = cycle_cnt1;
        end
        hold1 = 1'b0;
    endtask

    task automatic check_issues(input string tag);
        chk({tag, ".n_issue"}, ia.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s.addrA%0d", tag, i), (i < ia.size()) ? ia[i] : -1, exp_a[i]);
            chk($sformatf("%s.addrB%0d", tag, i), (i < ib.size()) ? ib[i] : -1, exp_b[i]);
        end
        chk({tag, ".n_mac"}, mac_cyc.size(), 8);
    endtask

    task automatic check_run(input string tag, input int wc[4], input int exp_done,
                             input int exp_busy);
        chk({tag, ".n_wr"}, rw_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s.wr_cyc%0d", tag, i), (i < rw_cyc.size()) ? rw_cyc[i] : -1, wc[i]);
            chk($sformatf("%s.wr_addr%0d", tag, i), (i < rw_addr.size()) ? rw_addr[i] : -1, i);
        end
        chk({tag, ".n_done"}, done_cyc.size(), 1);
        chk({tag, ".done_cyc"}, (done_cyc.size() > 0) ? done_cyc[0] : -1, exp_done);
        chk({tag, ".busy_cycles"}, busy_n, exp_busy);
        chk({tag, ".strobe_pairing"}, bad_rw, 0);
`ifdef MM_CTRL_CYCLE_CNT_EN
        chk({tag, ".cycle_cnt"}, cnt_max, exp_busy);
`else
        chk({tag, ".cycle_cnt"}, cnt_max, 0);
`endif
    endtask

    int d2, nw2;

    initial begin
        rst1 = 1'b0; rst2 = 1'b0;
        start1 = 1'b0; start2 = 1'b0;
        hold1 = 1'b0; hold2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = ((i >> 2) == (i & 3)) ? 8'd1 : 8'd0;
            mem_b[i] = 8'(i);
            r_mem[i] = -1;
        end

        #3;
        chk("reset.outs1", {busy1, done1, en_A1, en_B1, mac_acc1, mac_clear1, en_R1, rw_R1,
                            addr_A1, addr_B1, addr_R1}, 0);
        chk("reset.cnt1", cycle_cnt1, 0);
        chk("reset.outs2", {busy2, done2, en_A2, en_B2, mac_acc2, mac_clear2, en_R2, rw_R2,
                            addr_A2, addr_B2, addr_R2}, 0);
        repeat (2) @(negedge clk);
        rst1 = 1'b1; rst2 = 1'b1;
        repeat (2) @(negedge clk);

        // Plain run
        start1 = 1'b1;
        run1(14, 0, 0, 0, 0);
        check_issues("plain");
        chk("plain.n_clear", clr_cyc.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("plain.clr_cyc%0d", i), (i < clr_cyc.size()) ? clr_cyc[i] : -1, exp_clr[i]);
        chk("plain.first_mac", (mac_cyc.size() > 0) ? mac_cyc[0] : -1, 2);
        check_run("plain", wc_plain, 11, 10);
        start1 = 1'b0;
        repeat (3) @(negedge clk);

        // Three held cycles starting at cycle 3
        start1 = 1'b1;
        run1(17, 3, 3, 0, 0);
        check_issues("hold");
        chk("hold.strobes_in_hold", held_strobes, 0);
        check_run("hold", wc_hold, 14, 13);
        start1 = 1'b0;
        repeat (3) @(negedge clk);

        // Second start edge mid-run must be ignored
        start1 = 1'b1;
        run1(18, 0, 0, 3, 5);
        check_run("retoggle", wc_plain, 11, 10);
        start1 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in cycle 5, then restart with start already high
        start1 = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("abort.busy_before", busy1, 1);
        rst1 = 1'b0;
        #1;
        chk("abort.outs", {busy1, done1, en_A1, en_B1, mac_acc1, mac_clear1, en_R1, rw_R1,
                           addr_A1, addr_B1, addr_R1}, 0);
        chk("abort.cnt", cycle_cnt1, 0);
        @(negedge clk);
        rst1 = 1'b1;
        run1(14, 0, 0, 0, 0);
        check_run("restart", wc_plain, 11, 10);
        start1 = 1'b0;

        // DIM=4, RD_LAT=2: identity * B must reproduce B
        @(negedge clk);
        start2 = 1'b1;
        d2 = 0;
        nw2 = 0;
        for (int n = 1; n <= 100 && d2 == 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (en_R2) nw2++;
            if (done2) d2 = n;
        end
        chk("mm.done_cyc", d2, 68);
        chk("mm.n_wr", nw2, 16);
`ifdef MM_CTRL_CYCLE_CNT_EN
        chk("mm.cycle_cnt", cycle_cnt2, 67);
`else
        chk("mm.cycle_cnt", cycle_cnt2, 0);
`endif
        @(negedge clk);
        for (int i = 0; i < 16; i++)
            chk($sformatf("mm.R%0d", i), r_mem[i], i);
        start2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
